// File: rtl/n_to_1_mux_pkg.sv
// Shared defaults and helpers for the n_to_1_mux single-bit selector.
package n_to_1_mux_pkg;

    localparam int unsigned N_DEF = 3;
    localparam int unsigned P_DEF = 8;

    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned p);
        return (sel < p);
    endfunction

endpackage

// File: rtl/n_to_1_mux_dec.sv
// Select decoder: one-hot enable per data input, all zeros when sel addresses no input.
module n_to_1_mux_dec
    import n_to_1_mux_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned P = P_DEF
) (
    input  logic [N-1:0] sel_i,
    output logic [P-1:0] onehot_o
);

    // Only indices below P are decoded, so out-of-range selects fall through to zero.
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < P; i++) begin
            if (sel_i == N'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/n_to_1_mux.sv
// P:1 single-bit mux with combinational and registered outputs.
// Optional select range flag sel_err enabled by macro N_TO_1_MUX_SEL_CHK_EN.
module n_to_1_mux
    import n_to_1_mux_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned P = P_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sel,
    input  logic [P-1:0] in,
    output logic         y,
    output logic         y_q
`ifdef N_TO_1_MUX_SEL_CHK_EN
    ,
    output logic         sel_err
`endif
);

    if ((P > (32'd1 << N)) || (P < 2) || (N < 1) || (N > 8)) begin : g_param_chk
        $error("n_to_1_mux: illegal parameters N=%0d P=%0d", N, P);
    end

    logic [P-1:0] onehot;
    logic         y_d;

    n_to_1_mux_dec #(
        .N (N),
        .P (P)
    ) u_dec (
        .sel_i    (sel),
        .onehot_o (onehot)
    );

    always_comb begin
        y   = |(in & onehot);
        y_d = y;
    end

`ifdef N_TO_1_MUX_SEL_CHK_EN
    logic sel_err_d;

    always_comb begin
        sel_err_d = !sel_in_range(32'(sel), P);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 1'b0;
`ifdef N_TO_1_MUX_SEL_CHK_EN
            sel_err <= 1'b0;
`endif
        end else begin
            y_q     <= y_d;
`ifdef N_TO_1_MUX_SEL_CHK_EN
            sel_err <= sel_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_n_to_1_mux.sv
// Scoreboard bench for n_to_1_mux; uses P=6 when N_TO_1_MUX_SEL_CHK_EN is defined.
module tb_n_to_1_mux;

    localparam int unsigned TN = 3;
`ifdef N_TO_1_MUX_SEL_CHK_EN
    localparam int unsigned TP = 6;
`else
    localparam int unsigned TP = 8;
`endif

    typedef struct {
        logic  y;
        logic  yq;
        logic  err;
        string name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TN-1:0] sel = 3'd7;
    logic [TP-1:0] din = '1;
    logic          y;
    logic          y_q;
`ifdef N_TO_1_MUX_SEL_CHK_EN
    logic          sel_err;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic rst_at_edge = 1'b0;

    always #5 clk = ~clk;

    n_to_1_mux #(
        .N (TN),
        .P (TP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .in      (din),
        .y       (y),
        .y_q     (y_q)
`ifdef N_TO_1_MUX_SEL_CHK_EN
        ,
        .sel_err (sel_err)
`endif
    );

    // Reference: the selected bit of the input vector, zero for selects past the last input.
    function automatic logic ref_y(input logic [TN-1:0] s, input logic [TP-1:0] d);
        int unsigned idx = s;
        if (idx < TP) return ((d >> idx) & 1) != 0;
        return 1'b0;
    endfunction

    function automatic logic ref_err(input logic [TN-1:0] s);
        return int'(s) >= int'(TP);
    endfunction

    task automatic step(input logic [TN-1:0] s, input logic [TP-1:0] d, input logic r, input string nm);
        exp_t e;
        @(negedge clk);
        e.yq  = (r && rst_at_edge) ? ref_y(sel, din) : 1'b0;
        e.err = (r && rst_at_edge) ? ref_err(sel) : 1'b0;
        sel   = s;
        din   = d;
        rst_n = r;
        e.y    = ref_y(s, d);
        e.name = nm;
        q.push_back(e);
        rst_at_edge = r;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (y !== e.y) begin
                    errors++;
                    $display("FAIL %s y: got %b expected %b (sel=%0d in=%b)", e.name, y, e.y, sel, din);
                end
                checks++;
                if (y_q !== e.yq) begin
                    errors++;
                    $display("FAIL %s y_q: got %b expected %b", e.name, y_q, e.yq);
                end
`ifdef N_TO_1_MUX_SEL_CHK_EN
                checks++;
                if (sel_err !== e.err) begin
                    errors++;
                    $display("FAIL %s sel_err: got %b expected %b", e.name, sel_err, e.err);
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [TP-1:0] v;
        step(3'd7, '1, 1'b0, "reset_hold");
        step(3'd7, '1, 1'b0, "reset_hold2");
        step(3'd7, '1, 1'b1, "reset_release");
        step(3'd7, '1, 1'b1, "first_edge");

        v = '0; v[0] = 1'b1;
        step(3'd0, v, 1'b1, "one_sel0");
        step(3'd1, v, 1'b1, "one_sel1");
        step(3'd2, v, 1'b1, "one_sel2");
        v = TP'(8'b10101010);
        step(3'd3, v, 1'b1, "alt_sel3");
        step(3'd4, v, 1'b1, "alt_sel4");
        step(3'd5, v, 1'b1, "alt_sel5");
        step(3'd6, '1, 1'b1, "ff_sel6");
        step(3'd7, '1, 1'b1, "ff_sel7");
        for (int s = 0; s < 8; s++) step(3'(s), '0, 1'b1, "zero_sweep");

        for (int b = 0; b < int'(TP); b++) begin
            v = '0;
            v[b] = 1'b1;
            for (int s = 0; s < 8; s++) step(3'(s), v, 1'b1, "walk_one");
        end

        v = '0; v[5] = 1'b1;
        step(3'd6, '1, 1'b1, "sel6_range");
        step(3'd6, '1, 1'b1, "sel6_err_edge");
        step(3'd5, v, 1'b1, "sel5_bit5");
        step(3'd5, v, 1'b1, "sel5_err_edge");

        for (int i = 0; i < 100; i++) begin
            step(3'($urandom_range(0, 7)), TP'($urandom), 1'b1, "random");
        end

        step(3'd6, '1, 1'b1, "pre_midreset");
        step(3'd6, '1, 1'b1, "pre_midreset2");
        step(3'd5, '1, 1'b0, "mid_reset");
        step(3'd5, '1, 1'b0, "mid_reset_hold");
        step(3'd5, '1, 1'b1, "mid_release");
        step(3'd6, '1, 1'b1, "post_release");
        step(3'd6, '1, 1'b1, "post_release2");

        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
